multi_queue_transmitter: RTL and testbench

MULTI_QUEUE_TRANSMITTER -- requirements
Module: multi_queue_transmitter

---
 rtl/multi_queue_transmitter.sv | 176 +++++++++++++++++
 tb/tb_multi_queue_transmitter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_queue_transmitter.sv
// Multi-queue serial transmitter: per-channel FIFOs with a round-robin grant feeding one framed serial line.
// Optional feature: define TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module multi_queue_transmitter #(
  parameter int CHANNELS   = 10,
  parameter int WORD_SIZE  = 4,
  parameter int DEPTH      = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          write_strobe,
  input  logic [CHANNELS-1:0]           write_enable,
  input  logic [WORD_SIZE-1:0]          write_data,
  output logic                          tx_line,
  output logic                          tx_busy,
  output logic [$clog2(CHANNELS)-1:0]   tx_channel,
  output logic [CHANNELS-1:0]           queue_full,
  output logic [CHANNELS-1:0]           queue_empty,
  output logic [CHANNELS-1:0]           overflow
);
  localparam int CH_W  = $clog2(CHANNELS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic                 par_q;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_q, state_d;
  logic                 strobe_q;
  logic                 rise;
  logic [WORD_SIZE-1:0] mem [CHANNELS][DEPTH];
  logic [PTR_W-1:0]     wr_ptr [CHANNELS];
  logic [PTR_W-1:0]     rd_ptr [CHANNELS];
  logic [PTR_W:0]       occ    [CHANNELS];
  logic [CHANNELS-1:0]  push, pop;
  logic [CH_W-1:0]      last_grant, grant;
  logic                 grant_vld;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 bit_end;
  logic [WORD_SIZE-1:0] shreg;

  assign rise    = write_strobe & ~strobe_q;
  assign bit_end = (bit_cnt == CNT_W'(BIT_CYCLES - 1));

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      queue_empty[c] = (occ[c] == '0);
      queue_full[c]  = (occ[c] == (PTR_W+1)'(DEPTH));
    end
  end

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    int idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = (int'(last_grant) + i) % CHANNELS;
      if (!grant_vld && !queue_empty[idx]) begin
        grant     = CH_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  // Full is judged on pre-edge occupancy, so a same-cycle pop never makes room.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      push[c] = rise & write_enable[c] & ~queue_full[c];
      pop[c]  = (state_q == IDLE) && grant_vld && (grant == CH_W'(c));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      overflow <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        occ[c]    <= '0;
      end
    end else begin
      strobe_q <= write_strobe;
      for (int c = 0; c < CHANNELS; c++) begin
        if (rise && write_enable[c] && queue_full[c]) overflow[c] <= 1'b1;
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        case ({push[c], pop[c]})
          2'b10:   occ[c] <= occ[c] + 1'b1;
          2'b01:   occ[c] <= occ[c] - 1'b1;
          default: occ[c] <= occ[c];
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= write_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tx_line = 1'b1;
    tx_busy = (state_q != IDLE);
    case (state_q)
      IDLE:  if (grant_vld) state_d = START;
      START: begin
        tx_line = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_line = shreg[0];
        if (bit_end && bit_idx == IDX_W'(WORD_SIZE - 1)) begin
`ifdef TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        tx_line = par_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP:    if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit timing and grant bookkeeping; counters restart in IDLE for every frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      bit_idx    <= '0;
      tx_channel <= '0;
      last_grant <= CH_W'(CHANNELS - 1);
    end else if (state_q == IDLE) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      if (grant_vld) begin
        tx_channel <= grant;
        last_grant <= grant;
      end
    end else begin
      bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
      if (state_q == DATA && bit_end) bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == IDLE && grant_vld) begin
      shreg <= mem[grant][rd_ptr[grant]];
`ifdef TX_PARITY_EN
      par_q <= ^mem[grant][rd_ptr[grant]];
`endif
    end else if (state_q == DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end
endmodule

// File: tb/tb_multi_queue_transmitter.sv
// Randomized scoreboard bench for multi_queue_transmitter (3 channels, 4-bit words, depth 2, 2 cycles/bit).
module tb_multi_queue_transmitter;
  localparam int CH = 3, W = 4, D = 2, BC = 2;
`ifdef TX_PARITY_EN
  localparam int NSLOT = W + 3;
`else
  localparam int NSLOT = W + 2;
`endif
  localparam int TOTAL = NSLOT * BC;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         write_strobe = 1'b0;
  logic [CH-1:0] write_enable = '0;
  logic [W-1:0] write_data = '0;
  logic         tx_line, tx_busy;
  logic [1:0]   tx_channel;
  logic [CH-1:0] queue_full, queue_empty, overflow;

  multi_queue_transmitter #(.CHANNELS(CH), .WORD_SIZE(W), .DEPTH(D), .BIT_CYCLES(BC)) dut (
    .clock(clock), .reset(reset), .write_strobe(write_strobe), .write_enable(write_enable),
    .write_data(write_data), .tx_line(tx_line), .tx_busy(tx_busy), .tx_channel(tx_channel),
    .queue_full(queue_full), .queue_empty(queue_empty), .overflow(overflow));

  always #5 clock = ~clock;

  int n_cmp = 0, n_fail = 0, frames_done = 0;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level at a given cycle position inside a frame.
  function automatic logic line_at(logic [W-1:0] word, int pos);
    int slot;
    slot = pos / BC;
    if (slot == 0) return 1'b0;
    if (slot <= W) return word[slot-1];
`ifdef TX_PARITY_EN
    if (slot == W + 1) return ^word;
`endif
    return 1'b1;
  endfunction

  // Reference model: queues of words, a round-robin pointer and a frame countdown.
  logic [W-1:0] mq [CH][$];
  logic [CH-1:0] m_ovf = '0;
  logic          m_prev = 1'b0;
  int            busy_left = 0, m_last = CH - 1, m_ch = 0;
  logic [W-1:0]  cur_word = '0;
  int            exp_q [$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) mq[c].delete();
      m_ovf = '0; m_prev = 1'b0; busy_left = 0; m_last = CH - 1; m_ch = 0;
      exp_q.delete();
    end else begin
      int pre [CH];
      logic rise;
      rise = write_strobe && !m_prev;
      m_prev = write_strobe;
      for (int c = 0; c < CH; c++) pre[c] = mq[c].size();
      if (busy_left > 0) busy_left--;
      else begin
        for (int i = 1; i <= CH; i++) begin
          int idx;
          idx = (m_last + i) % CH;
          if (busy_left == 0 && pre[idx] > 0) begin
            cur_word = mq[idx].pop_front();
            m_ch = idx; m_last = idx; busy_left = TOTAL;
            exp_q.push_back(idx * 256 + int'(cur_word));
          end
        end
      end
      if (rise)
        for (int c = 0; c < CH; c++)
          if (write_enable[c]) begin
            if (pre[c] == D) m_ovf[c] = 1'b1;
            else mq[c].push_back(write_data);
          end
    end
  end

  // Monitor: per-cycle flag checks and frame reassembly against the scoreboard.
  logic collecting = 1'b0;
  logic samples [$];
  int   frame_ch = 0;
  logic chan_moved = 1'b0;

  always @(negedge clock) begin
    logic [CH-1:0] e_empty, e_full;
    for (int c = 0; c < CH; c++) begin
      e_empty[c] = (mq[c].size() == 0);
      e_full[c]  = (mq[c].size() == D);
    end
    check("queue_empty", int'(queue_empty), int'(e_empty));
    check("queue_full", int'(queue_full), int'(e_full));
    check("overflow", int'(overflow), int'(m_ovf));
    check("tx_busy", int'(tx_busy), int'(busy_left > 0));
    check("tx_line", int'(tx_line), busy_left > 0 ? int'(line_at(cur_word, TOTAL - busy_left)) : 1);
    check("tx_channel", int'(tx_channel), m_ch);
    if (reset) begin
      collecting = 1'b0;
      samples.delete();
    end else if (tx_busy) begin
      if (!collecting) begin
        collecting = 1'b1; frame_ch = int'(tx_channel); chan_moved = 1'b0; samples.delete();
      end
      if (int'(tx_channel) != frame_ch) chan_moved = 1'b1;
      samples.push_back(tx_line);
    end else if (collecting) begin
      collecting = 1'b0;
      frames_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", frame_ch, -1);
      end else begin
        int e, bad;
        e = exp_q.pop_front();
        bad = 0;
        if (samples.size() != TOTAL) bad = 1;
        else for (int p = 0; p < TOTAL; p++)
          if (samples[p] != line_at(e[W-1:0], p)) bad = 1;
        check("frame_bits", bad, 0);
        check("frame_len", samples.size(), TOTAL);
        check("frame_channel", frame_ch, e / 256);
        check("channel_stable", int'(chan_moved), 0);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic write_pulse(logic [CH-1:0] en, logic [W-1:0] d);
    write_enable = en; write_data = d; write_strobe = 1'b1;
    tick(1);
    write_strobe = 1'b0;
    tick(1);
  endtask

  initial begin
    int f0;
    tick(3);
    reset = 1'b0;
    tick(1);
    // Single frame of 4'hA on channel 0.
    write_pulse(3'b001, 4'hA);
    tick(20);
    check("frames_after_A", frames_done, 1);
    // Long strobe hold must produce exactly one write.
    f0 = frames_done;
    write_enable = 3'b010; write_data = 4'h5; write_strobe = 1'b1;
    tick(10);
    write_strobe = 1'b0;
    tick(20);
    check("held_strobe_frames", frames_done - f0, 1);
    // Busy on channel 2, then one word into each queue: expect order 0,1,2.
    write_pulse(3'b100, 4'h3);
    tick(2);
    write_pulse(3'b001, 4'h1);
    write_pulse(3'b010, 4'h2);
    write_pulse(3'b100, 4'h4);
    tick(60);
    // Three writes to queue 1 while busy: third is dropped.
    write_pulse(3'b100, 4'hC);
    write_pulse(3'b010, 4'h6);
    write_pulse(3'b010, 4'h9);
    write_pulse(3'b010, 4'hE);
    #1;
    check("full1_directed", int'(queue_full[1]), 1);
    check("ovf1_directed", int'(overflow[1]), 1);
    tick(60);
    // Reset in the middle of the data bits.
    write_pulse(3'b011, 4'hB);
    tick(5);
    reset = 1'b1;
    #1;
    check("rst_tx_line", int'(tx_line), 1);
    check("rst_tx_busy", int'(tx_busy), 0);
    check("rst_empty", int'(queue_empty), 7);
    tick(2);
    reset = 1'b0;
    f0 = frames_done;
    tick(30);
    check("no_frame_after_rst", frames_done - f0, 0);
    // Randomized traffic with occasional resets.
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 2));
        reset = 1'b0;
      end
      write_strobe = 1'($urandom_range(0, 1));
      write_enable = 3'($urandom);
      write_data   = 4'($urandom);
      tick(1);
    end
    write_strobe = 1'b0;
    begin
      int budget;
      budget = 0;
      while (budget < 2000 && (busy_left > 0 || mq[0].size() + mq[1].size() + mq[2].size() > 0)) begin
        tick(1);
        budget++;
      end
      check("drain_timeout", int'(budget >= 2000), 0);
    end
    tick(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
